// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed common-anode 7-seg scanner with dead-time and frame-synchronous double buffer.
// Latency: every output registered, reflecting the previous cycle's cnt/idx; optional SEG7_BLINK_EN adds per-digit blink.
// Backpressure: none; load is a fire-and-forget strobe, last write before a frame boundary wins.
module seg7_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD_CYC = 16
`ifdef SEG7_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
`ifdef SEG7_BLINK_EN
    input  logic [DIGITS-1:0]     blink_in,
`endif
    output logic [3:0]            hex,
    output logic                  le,
    output logic                  point,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done,
    output logic                  pending
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    typedef enum logic {S_DEAD, S_DRIVE} state_e;

    typedef struct packed {
        logic [DIGITS-1:0][3:0] data;
        logic [DIGITS-1:0]      dp;
        logic [DIGITS-1:0]      blank;
`ifdef SEG7_BLINK_EN
        logic [DIGITS-1:0]      blink;
`endif
    } disp_t;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    state_e            state_q, state_d;
    disp_t             stage_q, stage_d;
    disp_t             shadow_q, shadow_d;
    logic              pending_q, pending_d;
    logic [3:0]        hex_q, hex_d;
    logic              le_q, le_d;
    logic              point_q, point_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              fd_q, fd_d;
    logic              last_cyc;
    logic              commit;

    assign last_cyc = enable && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    // With the scan stopped there is no tearing to avoid, so commit immediately.
    assign commit   = pending_q && (!enable || last_cyc);

    always_comb begin
        cnt_d = '0;
        idx_d = '0;
        if (enable) begin
            if (cnt_q == CNT_LAST) begin
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                idx_d = idx_q;
            end
        end
    end

    always_comb begin
        stage_d   = stage_q;
        shadow_d  = shadow_q;
        pending_d = pending_q && !commit;
        if (commit) begin
            shadow_d = stage_q;
        end
        if (load) begin
            stage_d.data  = data_in;
            stage_d.dp    = dp_in;
            stage_d.blank = blank_in;
`ifdef SEG7_BLINK_EN
            stage_d.blink = blink_in;
`endif
            pending_d     = 1'b1;
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

    logic [BF_W-1:0] bcnt_q, bcnt_d;
    logic            phase_q, phase_d;

    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (!enable) begin
            bcnt_d  = '0;
            phase_d = 1'b1;
        end else if (last_cyc) begin
            if (bcnt_q == BF_LAST) begin
                bcnt_d  = '0;
                phase_d = !phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q  <= '0;
            phase_q <= 1'b1;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end
`endif

    // State mirrors the slot phase of cnt_q, so it is derived from the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_DEAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = (cnt_d >= CNT_DEAD) ? S_DRIVE : S_DEAD;
    end

    always_comb begin
        hex_d   = hex_q;
        le_d    = 1'b1;
        point_d = 1'b0;
        an_d    = '1;
        fd_d    = last_cyc;
        if (enable && state_q == S_DRIVE) begin
            an_d[idx_q] = 1'b0;
            hex_d       = shadow_q.data[idx_q];
            le_d        = shadow_q.blank[idx_q];
            point_d     = shadow_q.dp[idx_q] & ~shadow_q.blank[idx_q];
`ifdef SEG7_BLINK_EN
            if (!phase_q && shadow_q.blink[idx_q]) begin
                le_d    = 1'b1;
                point_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            stage_q        <= '0;
            stage_q.blank  <= '1;
            shadow_q       <= '0;
            shadow_q.blank <= '1;
            pending_q      <= 1'b0;
            hex_q          <= 4'h0;
            le_q           <= 1'b1;
            point_q        <= 1'b0;
            an_q           <= '1;
            fd_q           <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            stage_q   <= stage_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            hex_q     <= hex_d;
            le_q      <= le_d;
            point_q   <= point_d;
            an_q      <= an_d;
            fd_q      <= fd_d;
        end
    end

    assign hex        = hex_q;
    assign le         = le_q;
    assign point      = point_q;
    assign an         = an_q;
    assign frame_done = fd_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (DIGITS=4, SCAN_DIV=8, DEAD_CYC=2); blink checks need SEG7_BLINK_EN.
module tb_seg7_scan_ctrl;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 8;
    localparam int DEAD_CYC = 2;
    localparam int FRAME    = DIGITS * SCAN_DIV;
`ifdef SEG7_BLINK_EN
    localparam int BLINK_FRAMES = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic [3:0]  blink_in = '0;
    logic [3:0]  hex;
    logic        le;
    logic        point;
    logic [3:0]  an;
    logic        frame_done;
    logic        pending;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEAD_CYC(DEAD_CYC)
`ifdef SEG7_BLINK_EN
        , .BLINK_FRAMES(BLINK_FRAMES)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
        .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
`ifdef SEG7_BLINK_EN
        .blink_in(blink_in),
`endif
        .hex(hex), .le(le), .point(point), .an(an),
        .frame_done(frame_done), .pending(pending)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: position within the frame plus staging/shadow copies.
    int          m_pos;
    logic [15:0] m_st_data, m_sh_data;
    logic [3:0]  m_st_dp, m_sh_dp, m_st_bl, m_sh_bl, m_st_bk, m_sh_bk;
    bit          m_pend;
    int          m_fcnt;
    bit          m_phase;
    logic [3:0]  e_hex, e_an;
    bit          e_le, e_pt, e_fd;

    typedef struct {
        logic [3:0] exp_an;
        logic [3:0] exp_hex;
        logic       exp_pt;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0;
        m_st_data = '0; m_sh_data = '0;
        m_st_dp = '0;   m_sh_dp = '0;
        m_st_bl = '1;   m_sh_bl = '1;
        m_st_bk = '0;   m_sh_bk = '0;
        m_pend = 0;
        m_fcnt = 0;
        m_phase = 1;
        e_hex = '0; e_an = '1; e_le = 1; e_pt = 0; e_fd = 0;
    endtask

    task automatic model_edge();
        int slot;
        int off;
        bit last;
        bit commit;
        if (!rst_n) begin
            model_reset();
            return;
        end
        slot   = m_pos / SCAN_DIV;
        off    = m_pos % SCAN_DIV;
        last   = enable && (m_pos == FRAME - 1);
        commit = m_pend && (!enable || last);
        e_an = '1; e_le = 1; e_pt = 0; e_fd = last;
        if (enable && off >= DEAD_CYC) begin
            e_an  = ~(4'b0001 << slot);
            e_hex = m_sh_data[slot*4 +: 4];
            e_le  = m_sh_bl[slot];
            e_pt  = m_sh_dp[slot] & ~m_sh_bl[slot];
`ifdef SEG7_BLINK_EN
            if (!m_phase && m_sh_bk[slot]) begin
                e_le = 1; e_pt = 0;
            end
`endif
        end
`ifdef SEG7_BLINK_EN
        if (!enable) begin
            m_fcnt = 0; m_phase = 1;
        end else if (last) begin
            m_fcnt++;
            if (m_fcnt == BLINK_FRAMES) begin
                m_fcnt = 0; m_phase = !m_phase;
            end
        end
`endif
        if (commit) begin
            m_sh_data = m_st_data; m_sh_dp = m_st_dp; m_sh_bl = m_st_bl; m_sh_bk = m_st_bk;
        end
        if (load) begin
            m_st_data = data_in; m_st_dp = dp_in; m_st_bl = blank_in; m_st_bk = blink_in;
        end
        m_pend = load || (m_pend && !commit);
        m_pos  = enable ? (m_pos + 1) % FRAME : 0;
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, ".an"}, an, e_an);
        chk({tag, ".le"}, le, e_le);
        chk({tag, ".point"}, point, e_pt);
        chk({tag, ".hex"}, hex, e_hex);
        chk({tag, ".frame_done"}, frame_done, e_fd);
        chk({tag, ".pending"}, pending, m_pend);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        cmp_all(tag);
    endtask

    // Next step() is the edge where the frame position equals p.
    task automatic run_until(input int p);
        int guard = 0;
        while (m_pos != p && guard < 2 * FRAME) begin
            step("run");
            guard++;
        end
        if (m_pos != p) chk("run_until_timeout", m_pos, p);
    endtask

    task automatic load_vals(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        data_in = d; dp_in = dp; blank_in = bl; load = 1;
        step("load");
        load = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{exp_an: 4'b1110, exp_hex: 4'h1, exp_pt: 1'b0};
        tbl[1] = '{exp_an: 4'b1101, exp_hex: 4'h2, exp_pt: 1'b0};
        tbl[2] = '{exp_an: 4'b1011, exp_hex: 4'h3, exp_pt: 1'b1};
        tbl[3] = '{exp_an: 4'b0111, exp_hex: 4'h4, exp_pt: 1'b0};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.an", an, 4'hF);
        chk("rst.le", le, 1'b1);
        chk("rst.hex", hex, 4'h0);
        chk("rst.point", point, 1'b0);
        chk("rst.pending", pending, 1'b0);
        chk("rst.frame_done", frame_done, 1'b0);

        rst_n = 1; enable = 1;
        step("wake"); step("wake");
        chk("wake.dead_an", an, 4'hF);
        step("wake");
        chk("wake.an", an, 4'b1110);
        chk("wake.le", le, 1'b1);

        // Basic scan
        run_until(0);
        load_vals(16'h4321, 4'b0100, 4'b0000);
        chk("basic.pending_set", pending, 1'b1);
        run_until(FRAME - 1);
        step("commit");
        chk("basic.pending_clr", pending, 1'b0);
        chk("basic.frame_done", frame_done, 1'b1);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < SCAN_DIV; c++) begin
                step("scan");
                if (c < DEAD_CYC) begin
                    chk("scan.dead_an", an, 4'hF);
                    chk("scan.dead_le", le, 1'b1);
                end else begin
                    chk("scan.an", an, tbl[d].exp_an);
                    chk("scan.hex", hex, tbl[d].exp_hex);
                    chk("scan.point", point, tbl[d].exp_pt);
                    chk("scan.le", le, 1'b0);
                end
                if (d == 3 && c == SCAN_DIV - 1) chk("scan.frame_done", frame_done, 1'b1);
            end
        end

        // No tearing
        run_until(12);
        load_vals(16'hABCD, 4'b0100, 4'b0000);
        run_until(26);
        step("tear");
        chk("tear.an", an, 4'b0111);
        chk("tear.hex_old", hex, 4'h4);
        chk("tear.pending", pending, 1'b1);
        run_until(FRAME - 1);
        step("tear");
        chk("tear.pending_clr", pending, 1'b0);
        run_until(4);
        step("tear");
        chk("tear.hex_d0", hex, 4'hD);
        run_until(28);
        step("tear");
        chk("tear.hex_d3", hex, 4'hA);

        // Load on the commit cycle
        run_until(5);
        load_vals(16'h5678, 4'b0000, 4'b0000);
        run_until(FRAME - 1);
        load_vals(16'h1111, 4'b0000, 4'b0000);
        chk("coll.pending", pending, 1'b1);
        run_until(3);
        step("coll");
        chk("coll.hex_old", hex, 4'h8);
        run_until(FRAME - 1);
        step("coll");
        chk("coll.pending_clr", pending, 1'b0);
        run_until(11);
        step("coll");
        chk("coll.hex_new", hex, 4'h1);

        // Enable low, immediate commit, re-enable
        enable = 0;
        repeat (3) step("dis");
        chk("dis.an", an, 4'hF);
        chk("dis.le", le, 1'b1);
        load_vals(16'h9ABC, 4'b0000, 4'b0000);
        chk("dis.pending", pending, 1'b1);
        step("dis");
        chk("dis.commit", pending, 1'b0);
        enable = 1;
        step("reen"); step("reen");
        chk("reen.dead", an, 4'hF);
        step("reen");
        chk("reen.an", an, 4'b1110);
        chk("reen.hex", hex, 4'hC);

        // Blanked digit
        load_vals(16'h9ABC, 4'b0010, 4'b0010);
        run_until(FRAME - 1);
        step("blank");
        run_until(10);
        step("blank");
        chk("blank.an", an, 4'b1101);
        chk("blank.le", le, 1'b1);
        chk("blank.point", point, 1'b0);

        // Asynchronous reset between clock edges
        load_vals(16'h2222, 4'b0000, 4'b0000);
        #2;
        rst_n = 0;
        #1;
        chk("arst.an", an, 4'hF);
        chk("arst.le", le, 1'b1);
        chk("arst.hex", hex, 4'h0);
        chk("arst.point", point, 1'b0);
        chk("arst.pending", pending, 1'b0);
        model_reset();
        step("arst");
        rst_n = 1;
        repeat (3) step("arst_rel");
        chk("arst_rel.an", an, 4'b1110);
        chk("arst_rel.le", le, 1'b1);

        // Randomized run against the model
        for (int i = 0; i < 800; i++) begin
            enable   = ($urandom_range(0, 19) != 0);
            load     = ($urandom_range(0, 7) == 0);
            data_in  = 16'($urandom);
            dp_in    = 4'($urandom);
            blank_in = 4'($urandom);
            blink_in = 4'($urandom);
            step("rand");
        end
        load = 0; enable = 1; blink_in = '0;

`ifdef SEG7_BLINK_EN
        rst_n = 0;
        step("blink_rst");
        rst_n = 1;
        blink_in = 4'b0001;
        load_vals(16'h4321, 4'b0000, 4'b0000);
        blink_in = 4'b0000;
        run_until(0);
        for (int f = 2; f < 8; f++) begin
            run_until(4);
            step("blink");
            chk("blink.d0_le", le, (((f - 1) / 2) % 2 == 0) ? 1'b0 : 1'b1);
            chk("blink.d0_an", an, 4'b1110);
            run_until(12);
            step("blink");
            chk("blink.d1_le", le, 1'b0);
            run_until(0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit common-anode 7-segment display.
- Drives a single shared hex-to-7-segment decoder with inputs D3..D0, LE (active-high blank) and point (active-high DP; decoder outputs are active-low).
- Sequences digits via active-low anode enables and inserts a dead-time blank between digits to prevent ghosting.
- Display data is double-buffered and committed only at frame boundaries, so the display never tears.

Parameters:
- DIGITS, 4, number of digits scanned (legal 1..8).
- SCAN_DIV, 50000, clocks per digit slot (legal ≥ DEAD_CYC+1).
- DEAD_CYC, 16, clocks at start of each slot with all anodes off and LE=1 (legal ≥ 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scan enable; 0 = display dark, scan held.
- load  in  1  single-cycle strobe; captures data_in, dp_in and blank_in into staging.
- data_in  in  4*DIGITS  hex nibbles; digit i = data_in[4i+3:4i].
- dp_in  in  DIGITS  decimal point per digit, 1 = lit.
- blank_in  in  DIGITS  per-digit blank, 1 = dark.
- hex  out  4  to decoder D3..D0.
- le  out  1  to decoder LE, 1 = all segments off.
- point  out  1  to decoder point, 1 = DP lit.
- an  out  DIGITS  anode enables, active-low.
- frame_done  out  1  one-cycle pulse at the end of each full scan.
- pending  out  1  staging holds data not yet committed.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Outputs: hex=0, le=1, point=0, an=all 1, frame_done=0, pending=0.
  - Counters: cnt=0, idx=0.
  - Staging and shadow registers: data=0, dp=0, blank=all 1.
- All outputs are registered. Each output reflects the cnt/idx value of the previous cycle (1-cycle latency).
- Counters:
  - cnt runs 0..SCAN_DIV-1, then wraps to 0 and increments idx.
  - idx runs 0..DIGITS-1, then wraps to 0.
- FSM, two states per slot:
  - DEAD (cnt < DEAD_CYC): an=all 1, le=1, point=0, hex holds its last value.
  - DRIVE (cnt ≥ DEAD_CYC): an[idx]=0 (others 1), hex=shadow nibble idx, le=shadow blank[idx], point=shadow dp[idx] & ~shadow blank[idx].
- frame_done: pulses 1 in the cycle after cnt==SCAN_DIV-1 with idx==DIGITS-1.
- Staging and commit:
  - load=1 writes staging; pending=1 the next cycle.
  - Commit: staging copies to shadow when cnt==SCAN_DIV-1 and idx==DIGITS-1 (last cycle of the frame) and pending=1. pending clears on that same edge.
- Boundary cases:
  - load while pending=1: staging is overwritten, last write wins, only one commit.
  - load in the same cycle as a commit: the old staging commits; the new data enters staging; pending stays 1.
- enable=0:
  - cnt and idx are forced to 0 each cycle; outputs take DEAD values.
  - Commit happens on any cycle with pending=1; frame_done=0.
- enable 0→1: scan starts at idx=0, cnt=0 (DEAD first).
- Reset mid-frame: immediate return to reset values; staged data is lost.
- DIGITS=1: idx stays at 0; frame_done pulses every SCAN_DIV clocks.

Optional Feature:
- Macro: SEG7_BLINK_EN.
- When defined:
  - Adds input blink_in [DIGITS] (staged and committed with the other fields) and parameter BLINK_FRAMES (default 64).
  - A frame counter toggles blink_phase every BLINK_FRAMES frame_done pulses; reset value is phase=1 (on).
  - While phase=0, digits with blink=1 force le=1 and point=0 in DRIVE; their anode is still enabled.
  - enable=0 clears the frame counter and sets phase=1.
- When undefined: no blink_in port, no frame counter; behaviour exactly as above.

Test Plan:
- Bench configuration: DIGITS=4, SCAN_DIV=8, DEAD_CYC=2.
- Reset: hold rst_n=0 mid-scan -> an=4'hF, le=1, hex=0, point=0, pending=0 with no clock edge needed; first DRIVE after release shows idx 0, blanked because shadow blank=all 1.
- Basic scan: load data_in=16'h4321, dp_in=4'b0100, blank_in=0, enable=1 -> pending=1 until the first frame end. Next frame shows:
  - an=1110 with hex=1
  - an=1101 with hex=2
  - an=1011 with hex=3, point=1
  - an=0111 with hex=4
  - Each digit is driven for 6 cycles after 2 dead cycles; frame_done pulses every 32 clocks.
- No tearing: load 16'hABCD mid-frame -> remaining digits of that frame still show 4321; the next frame shows D,C,B,A; pending falls on the commit edge.
- Load collision: load 16'h1111 exactly on the commit cycle, then nothing more -> the frame after shows the previously staged value; the following frame shows 1111.
- Enable/blank: enable=0 -> an=4'hF, le=1 continuously; a load commits the next cycle. Re-enable -> first 2 cycles dead, then idx 0. blank_in=4'b0010 -> digit 1 has le=1, point=0 while an=1101.
- Blink (SEG7_BLINK_EN, BLINK_FRAMES=2): blink_in=4'b0001 -> digit 0 shows le=0 for 2 frames, then le=1 for 2 frames, repeating; other digits are unaffected.
